// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX core between two byte streams,
// with a lock timeout that reclaims the transmitter from a stalled owner.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 4800000,
  parameter int TO_WIDTH = 23
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_ACCEPT, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic last_owner_q, last_owner_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_start_q, tx_start_d;
  logic last_q, last_d;
  logic timeout_err_q, timeout_err_d;
  logic hs, pick_b, own_last;
  logic [7:0] own_data;
  assign a_ready = (state_q == LOCKED) & grant_q[0] & ~tx_busy;
  assign b_ready = (state_q == LOCKED) & grant_q[1] & ~tx_busy;
  assign hs = (a_ready & a_valid) | (b_ready & b_valid);
  assign own_data = grant_q[1] ? b_data : a_data;
  assign own_last = grant_q[1] ? b_last : a_last;
  // last_owner_q=1 means B; on contention the other requester wins
  assign pick_b = b_valid & ~(a_valid & last_owner_q);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_owner_d = last_owner_q;
    cnt_d = cnt_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    last_d = last_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (a_valid | b_valid) begin
        grant_d = pick_b ? 2'b10 : 2'b01;
        state_d = LOCKED;
        cnt_d = '0;
      end
      LOCKED: if (hs) begin
        tx_data_d = own_data;
        last_d = own_last;
        tx_start_d = 1'b1;
        state_d = WAIT_ACCEPT;
        cnt_d = '0;
      end else if (cnt_q == TO_WIDTH'(LOCK_TIMEOUT - 1)) begin
        state_d = IDLE;
        grant_d = 2'b00;
        timeout_err_d = 1'b1;
        last_owner_d = grant_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WAIT_ACCEPT: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) begin
        if (last_q) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_owner_d = grant_q[1];
        end else begin
          state_d = LOCKED;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_owner_q <= 1'b1;
      cnt_q <= '0;
      tx_data_q <= 8'h00;
      tx_start_q <= 1'b0;
      last_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_owner_q <= last_owner_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_q <= last_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign grant = grant_q;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign timeout_err = timeout_err_q;
  a_grant_onehot0: assert property (@(posedge clk_48mhz) disable iff (reset) $onehot0(grant_q));
  a_start_pulse: assert property (@(posedge clk_48mhz) disable iff (reset) tx_start_q |=> !tx_start_q);
  a_ready_excl: assert property (@(posedge clk_48mhz) disable iff (reset) !(a_ready && b_ready));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; drivers queue expected bytes per requester, a monitor
// checks arbitration decisions, transmitted bytes and release behaviour as the DUT produces them.
module tb_uart_tx_arbiter;
  logic clk_48mhz = 1'b0;
  logic reset = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, a_last = 1'b0, b_last = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic a_ready, b_ready, tx_start, timeout_err, tx_busy;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic uart_busy = 1'b0, force_busy = 1'b0;
  bit rnd_dur = 1'b0;
  int total = 0, bad = 0, n_start = 0, to_allow = 0;
  logic [8:0] exp_a[$], exp_b[$];
  logic [1:0] glog[$];
  logic [1:0] m_last = 2'b10;
  logic last_pop = 1'b0;

  assign tx_busy = uart_busy | force_busy;
  always #5 clk_48mhz = ~clk_48mhz;

  uart_tx_arbiter #(.LOCK_TIMEOUT(16), .TO_WIDTH(5)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner of a packet-boundary decision: the lone requester, or on contention the one that did not own last
  function automatic logic [1:0] pick(input logic av, input logic bv, input logic [1:0] lo);
    if (av && bv) return (lo == 2'b10) ? 2'b01 : 2'b10;
    return av ? 2'b01 : (bv ? 2'b10 : 2'b00);
  endfunction

  function automatic logic [7:0] glog_code();
    logic [7:0] v = 8'h00;
    foreach (glog[i]) v = {v[5:0], glog[i]};
    return v;
  endfunction

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk_48mhz); #1; end
  endtask

  task automatic send_pkt(input bit who, input logic [7:0] d[$], input bit term, input int maxgap);
    for (int i = 0; i < d.size(); i++) begin
      bit lst, hs;
      int k;
      lst = term && (i == d.size() - 1);
      hs = 1'b0;
      k = 0;
      if (who) begin
        exp_b.push_back({lst, d[i]}); b_data = d[i]; b_last = lst; b_valid = 1'b1;
      end else begin
        exp_a.push_back({lst, d[i]}); a_data = d[i]; a_last = lst; a_valid = 1'b1;
      end
      while (!hs && k < 3000) begin
        @(negedge clk_48mhz);
        hs = who ? (b_valid && b_ready) : (a_valid && a_ready);
        @(posedge clk_48mhz); #1;
        k++;
      end
      if (!hs) chk(who ? "b_handshake_budget" : "a_handshake_budget", 32'(k), 32'(0));
      if (who) b_valid = 1'b0; else a_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk_48mhz); #1; end
    end
  endtask

  // UART TX core model: busy rises the cycle after a start pulse and holds for a set duration
  initial begin
    int ucnt;
    logic st;
    ucnt = 0;
    forever begin
      @(negedge clk_48mhz);
      st = tx_start;
      @(posedge clk_48mhz); #1;
      if (ucnt > 0) ucnt--;
      if (st) ucnt = rnd_dur ? int'($urandom_range(1, 8)) : 10;
      uart_busy = (ucnt > 0);
    end
  end

  initial begin
    logic [1:0] pg;
    logic pav, pbv;
    logic [8:0] e;
    pg = 2'b00; pav = 1'b0; pbv = 1'b0;
    forever begin
      @(negedge clk_48mhz);
      if (reset) m_last = 2'b10;
      else begin
        if (pg == 2'b00 && grant != 2'b00) begin
          chk("arb_winner", 32'(grant), 32'(pick(pav, pbv, m_last)));
          glog.push_back(grant);
        end
        if (pg != 2'b00 && grant != 2'b00 && grant != pg) chk("owner_switch_without_gap", 32'(grant), 32'(pg));
        if (pg != 2'b00 && grant == 2'b00) begin
          m_last = pg;
          if (!timeout_err) chk("release_only_after_last", 32'(last_pop), 32'(1));
        end
        if (a_ready && grant != 2'b01) chk("a_ready_not_owner", 32'(grant), 32'(1));
        if (b_ready && grant != 2'b10) chk("b_ready_not_owner", 32'(grant), 32'(2));
        if (tx_start) begin
          n_start++;
          if (grant == 2'b01 && exp_a.size() > 0) e = exp_a.pop_front();
          else if (grant == 2'b10 && exp_b.size() > 0) e = exp_b.pop_front();
          else e = 9'h1ff;
          if (e == 9'h1ff) chk("unexpected_tx_start", 32'(grant), 32'(0));
          else begin
            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
            last_pop = e[8];
          end
        end
        if (timeout_err) begin
          chk("timeout_expected", 32'(to_allow), 32'(1));
          to_allow = 0;
        end
      end
      pg = grant; pav = a_valid; pbv = b_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int k, n, r, s0;
    settle(3);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_a_ready", 32'(a_ready), 32'(0));
    chk("rst_b_ready", 32'(b_ready), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    @(negedge clk_48mhz); #2 reset = 1'b0;
    settle(2);

    glog.delete();
    fork
      send_pkt(1'b0, '{8'h48, 8'h69}, 1'b1, 0);
      send_pkt(1'b1, '{8'h41, 8'h42, 8'h43}, 1'b1, 0);
    join
    settle(40);
    chk("contention_grant_order", 32'(glog_code()), 32'(8'h06));

    glog.delete();
    fork
      begin send_pkt(1'b0, '{8'hA0}, 1'b1, 0); send_pkt(1'b0, '{8'hA1}, 1'b1, 0); end
      begin send_pkt(1'b1, '{8'hB0}, 1'b1, 0); send_pkt(1'b1, '{8'hB1}, 1'b1, 0); end
    join
    settle(40);
    chk("round_robin_grants", 32'(glog_code()), 32'(8'h66));

    to_allow = 1;
    fork send_pkt(1'b0, '{8'h55}, 1'b0, 0); join_none
    k = 0;
    while (!tx_busy && k < 200) begin @(negedge clk_48mhz); k++; end
    while (tx_busy && k < 400) begin @(negedge clk_48mhz); k++; end
    fork send_pkt(1'b1, '{8'hB7}, 1'b1, 0); join_none
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk_48mhz); n++; end
    chk("timeout_latency", 32'(n), 32'(17));
    chk("timeout_grant_released", 32'(grant), 32'(0));
    @(negedge clk_48mhz);
    chk("timeout_single_pulse", 32'(timeout_err), 32'(0));
    chk("timeout_b_granted", 32'(grant), 32'(2));
    wait fork;
    settle(40);
    chk("timeout_consumed", 32'(to_allow), 32'(0));

    @(posedge clk_48mhz); #1 force_busy = 1'b1;
    fork send_pkt(1'b0, '{8'hC3}, 1'b1, 0); join_none
    k = 0;
    while (grant != 2'b01 && k < 50) begin @(negedge clk_48mhz); k++; end
    chk("bp_grant", 32'(grant), 32'(1));
    r = 0;
    repeat (6) begin @(negedge clk_48mhz); r += int'(a_ready); end
    chk("bp_ready_held_low", 32'(r), 32'(0));
    s0 = n_start;
    @(posedge clk_48mhz); #1 force_busy = 1'b0;
    settle(40);
    chk("bp_single_start", 32'(n_start - s0), 32'(1));
    wait fork;

    fork send_pkt(1'b0, '{8'hD1, 8'hD2}, 1'b1, 0); join_none
    k = 0;
    while (!tx_busy && k < 200) begin @(negedge clk_48mhz); k++; end
    repeat (2) @(negedge clk_48mhz);
    fork send_pkt(1'b1, '{8'hE1}, 1'b1, 0); join_none
    #2 reset = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant), 32'(0));
    chk("async_rst_a_ready", 32'(a_ready), 32'(0));
    chk("async_rst_tx_start", 32'(tx_start), 32'(0));
    chk("async_rst_tx_data", 32'(tx_data), 32'(0));
    repeat (2) @(negedge clk_48mhz);
    #2 reset = 1'b0;
    @(negedge clk_48mhz);
    chk("post_reset_a_wins", 32'(grant), 32'(1));
    wait fork;
    settle(40);

    rnd_dur = 1'b1;
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          logic [7:0] qa[$];
          qa = {};
          repeat ($urandom_range(1, 4)) qa.push_back(8'($urandom));
          send_pkt(1'b0, qa, 1'b1, 3);
        end
      end
      begin
        for (int p = 0; p < 8; p++) begin
          logic [7:0] qb[$];
          qb = {};
          repeat ($urandom_range(1, 4)) qb.push_back(8'($urandom));
          send_pkt(1'b1, qb, 1'b1, 3);
        end
      end
    join
    settle(40);
    chk("exp_a_drained", 32'(exp_a.size()), 32'(0));
    chk("exp_b_drained", 32'(exp_b.size()), 32'(0));
    chk("final_idle_grant", 32'(grant), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the SoC's single UART transmitter between two byte-stream requesters. Requester A is the CPU console path and requester B is the debug/monitor path. Ownership is granted per packet: a packet is a sequence of bytes ending in one flagged last. Arbitration is round-robin at packet boundaries, and a lock timeout reclaims the UART from a stalled owner. The block sits between the requesters and the UART TX core, which drives the PMOD B TX pin.

Parameters:
LOCK_TIMEOUT, 4800000, cycles an owner may hold the lock with no byte offered before forced release (100 ms at 48 MHz)
TO_WIDTH, 23, width of the timeout counter; must satisfy 2^TO_WIDTH > LOCK_TIMEOUT

Ports:
clk_48mhz  input  1  system clock
reset  input  1  asynchronous, active-high reset
a_valid  input  1  requester A byte offered
a_data  input  8  requester A byte
a_last  input  1  requester A byte is final of packet
a_ready  output  1  requester A byte accepted this cycle when a_valid
b_valid  input  1  requester B byte offered
b_data  input  8  requester B byte
b_last  input  1  requester B byte is final of packet
b_ready  output  1  requester B byte accepted this cycle when b_valid
tx_data  output  8  byte to UART TX core
tx_start  output  1  one-cycle start pulse to UART TX core
tx_busy  input  1  UART TX core shifting
grant  output  2  one-hot current owner, [0]=A, [1]=B; 00 when idle
timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock, clk_48mhz; reset is asynchronous and active-high.
- Reset values: state=IDLE; grant=00; a_ready=b_ready=0; tx_start=0; tx_data=8'h00; timeout_err=0; timeout counter=0; last_owner=B, so A wins the first contention.
- FSM states: IDLE, LOCKED, WAIT_ACCEPT, WAIT_DONE.
- IDLE:
  - Only one valid asserted: that requester is granted.
  - Both valid: the requester other than last_owner is granted.
  - grant is registered and visible the next cycle. Next state LOCKED, timeout counter cleared.
  - Neither valid: stay in IDLE.
- LOCKED:
  - Ready is combinational: owner_ready = (state==LOCKED) & owner & !tx_busy. The non-owner's ready is always 0.
  - Handshake (owner valid & ready) in cycle N: tx_data is registered from owner data, the last flag is captured, tx_start=1 in cycle N+1 only, and the FSM enters WAIT_ACCEPT. Timeout counter cleared.
  - No handshake: the counter increments. When it reaches LOCK_TIMEOUT-1, the next state is IDLE, grant=00, timeout_err=1 for one cycle, and last_owner=owner.
- WAIT_ACCEPT: wait for tx_busy=1, then go to WAIT_DONE. The timeout counter is idle in this state.
- WAIT_DONE: wait for tx_busy=0.
  - Captured last=1: go to IDLE, grant=00, last_owner=owner.
  - Otherwise: go back to LOCKED with the counter cleared.
- Grant latency: IDLE with a request at cycle N gives grant at N+1, ready at N+1 if tx_busy=0, and earliest tx_start at N+2.
- Inter-packet gap: at least one IDLE cycle between packets, so grant drops to 00 for at least one cycle, even when the same requester continues.
- Non-owner requests are held off with no data loss; requesters must keep valid and data stable until ready.
- Owner deasserting valid mid-packet is legal; the lock is held until timeout.
- tx_busy already high on entry to LOCKED: ready stays 0 and the counter still runs.
- Byte with last=1 after a timeout release is treated as a new packet, arbitrated normally.
- Reset mid-packet: immediate return to reset values. A tx_start pulse in flight is cancelled. No byte is replayed.
- Assertions:
  - grant is one-hot or zero.
  - tx_start is never high on two consecutive cycles.
  - a_ready & b_ready is never 1.

Test Plan:
- Single packet, A sends 8'h48, 8'h69(last), UART model with 10-cycle busy: grant=01 one cycle after a_valid; tx_data 48 then 69 with one tx_start each; grant=00 after busy falls on the second byte.
- Contention: A and B both valid from IDLE after reset: A granted; B's 3-byte packet (41,42,43 last) follows only after A's last byte completes; B's first tx_start comes after at least one grant=00 cycle.
- Round-robin: A and B continuously request 1-byte packets: grants alternate 01,10,01,10 across 4 packets.
- Timeout with LOCK_TIMEOUT=16: A sends one non-last byte then drops valid: exactly 16 LOCKED cycles later timeout_err pulses once, grant=00, and pending B is granted the next cycle.
- Back-pressure: tx_busy held high on grant: a_ready stays 0; when tx_busy falls the byte transfers and tx_start is asserted exactly once.
- Async reset mid-packet, asserted between clock edges during WAIT_DONE: all outputs at reset values immediately; after release, A and B both valid gives A granted (last_owner=B).
